// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte stream and writes
// little-endian 32-bit words to consecutive instruction memory addresses.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              err,
  output logic [2:0]        dbg_state
);

  // Handshake: a byte transfers on a rising edge where in_valid & in_ready are both 1.
  typedef enum logic [2:0] {
    S_LEN0 = 3'd0,
    S_LEN1 = 3'd1,
    S_DATA = 3'd2,
    S_CHK  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        chk_q, chk_d;
  logic [23:0]       asm_q, asm_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [ADDR_W:0]   word_idx_q, word_idx_d;
  logic              in_ready_q, in_ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              core_hold_q, core_hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              accept;
  logic [15:0]       len_new;

  assign accept  = in_valid & in_ready_q;
  assign len_new = {in_data, len_q[7:0]};

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    chk_d      = chk_q;
    asm_d      = asm_q;
    byte_idx_d = byte_idx_q;
    word_idx_d = word_idx_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      S_LEN0: begin
        if (accept) begin
          len_d[7:0] = in_data;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          len_d = len_new;
          if (32'(len_new) > (32'd1 << ADDR_W)) state_d = S_ERR;
          else if (len_new == 16'd0)            state_d = S_CHK;
          else                                  state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          chk_d      = chk_q ^ in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            we_d       = 1'b1;
            wdata_d    = {in_data, asm_q};
            addr_d     = word_idx_q[ADDR_W-1:0];
            word_idx_d = word_idx_q + 1'b1;
            if (32'(word_idx_q) + 32'd1 == 32'(len_q)) state_d = S_CHK;
          end else begin
            // Shift right so that after three bytes asm holds {b2, b1, b0}.
            asm_d = {in_data, asm_q[23:8]};
          end
        end
      end
      S_CHK: begin
        if (accept) state_d = (in_data == chk_q) ? S_DONE : S_ERR;
      end
      default: state_d = state_q;
    endcase
    // Status outputs are registered from the next state so they move on the deciding edge.
    in_ready_d  = (state_d == S_LEN0) || (state_d == S_LEN1) ||
                  (state_d == S_DATA) || (state_d == S_CHK);
    core_hold_d = (state_d != S_DONE);
    done_d      = (state_d == S_DONE);
    err_d       = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_LEN0;
      len_q       <= '0;
      chk_q       <= '0;
      asm_q       <= '0;
      byte_idx_q  <= '0;
      word_idx_q  <= '0;
      in_ready_q  <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      core_hold_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      chk_q       <= chk_d;
      asm_q       <= asm_d;
      byte_idx_q  <= byte_idx_d;
      word_idx_q  <= word_idx_d;
      in_ready_q  <= in_ready_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      core_hold_q <= core_hold_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_hold  = core_hold_q;
  assign done       = done_q;
  assign err        = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed streams, expected writes queued by the driver side
// and checked by an independent monitor on every imem_we strobe.
module tb_imem_loader;

  localparam int ADDR_W = 8;
  localparam int EW     = ADDR_W + 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_hold;
  logic              done;
  logic              err;
  logic [2:0]        dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_hold(core_hold), .done(done),
    .err(err), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired, got no finish, need finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, need 0x%0h", name, act, exp);
    end
  endtask

  // monitor: every strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (rst === 1'b1 && imem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h, need no write",
                 imem_addr, imem_wdata);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          failures++;
          $display("FAIL write: got addr=0x%0h data=0x%0h, need addr=0x%0h data=0x%0h",
                   imem_addr, imem_wdata, e[EW-1:32], e[31:0]);
        end
      end
    end
  end

  // driver tasks (called aligned to a falling edge)
  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_in_ready",   64'(in_ready),   64'd0);
    check("rst_imem_we",    64'(imem_we),    64'd0);
    check("rst_imem_addr",  64'(imem_addr),  64'd0);
    check("rst_imem_wdata", 64'(imem_wdata), 64'd0);
    check("rst_core_hold",  64'(core_hold),  64'd1);
    check("rst_done",       64'(done),       64'd0);
    check("rst_err",        64'(err),        64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic check_end(input string tag, input logic exp_done, input logic exp_err);
    check({tag, "_done"},      64'(done),      64'(exp_done));
    check({tag, "_err"},       64'(err),       64'(exp_err));
    check({tag, "_core_hold"}, 64'(core_hold), 64'(!exp_done));
    check({tag, "_in_ready"},  64'(in_ready),  64'd0);
    check({tag, "_pending"},   64'(exp_q.size()), 64'd0);
  endtask

  logic [7:0] s_n1[7]  = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h43};
  logic [7:0] s_new[7] = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
  logic [7:0] s_mid[9] = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // N=1 single load
    do_reset();
    exp_q.push_back({8'd0, 32'h0050_0013});
    for (int i = 0; i < 7; i++) send_byte(s_n1[i]);
    check_end("n1", 1'b1, 1'b0);
    idle(2);
    check("n1_hold_addr",  64'(imem_addr),  64'd0);
    check("n1_hold_wdata", 64'(imem_wdata), 64'h0050_0013);
    send_byte(8'h99);
    check("n1_done_sticky", 64'(done), 64'd1);

    // N=0
    do_reset();
    send_byte(8'h00); send_byte(8'h00);
    check("n0_not_done_yet", 64'(done), 64'd0);
    send_byte(8'h00);
    check_end("n0", 1'b1, 1'b0);

    // bad checksum: write still happens
    do_reset();
    exp_q.push_back({8'd0, 32'h0050_0013});
    for (int i = 0; i < 6; i++) send_byte(s_n1[i]);
    send_byte(8'h42);
    check_end("badchk", 1'b0, 1'b1);

    // oversize length: N=257
    do_reset();
    send_byte(8'h01);
    send_byte(8'h01);
    check_end("oversize", 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) send_byte(8'h5A);
    check_end("oversize_ignored", 1'b0, 1'b1);

    // full capacity N=256 with random valid gaps
    do_reset();
    begin
      logic [7:0] x;
      logic [31:0] w;
      x = 8'h00;
      send_byte(8'h00);
      send_byte(8'h01);
      for (int k = 0; k < 256; k++) begin
        w = 32'hA500_0000 | 32'(k);
        exp_q.push_back({8'(k), w});
        for (int b = 0; b < 4; b++) begin
          x = x ^ w[8*b +: 8];
          idle($urandom_range(0, 2));
          send_byte(w[8*b +: 8]);
        end
      end
      check("full_chk_value", 64'(x), 64'h00);
      idle($urandom_range(0, 3));
      send_byte(x);
    end
    check_end("full", 1'b1, 1'b0);
    check("full_last_addr", 64'(imem_addr), 64'hFF);

    // mid-load reset after payload byte 2 of word 1
    do_reset();
    exp_q.push_back({8'd0, 32'h4433_2211});
    for (int i = 0; i < 9; i++) send_byte(s_mid[i]);
    check("mid_pending", 64'(exp_q.size()), 64'd0);
    check("mid_not_done", 64'(done), 64'd0);
    do_reset();
    exp_q.push_back({8'd0, 32'hDEAD_BEEF});
    for (int i = 0; i < 7; i++) send_byte(s_new[i]);
    check_end("mid_new", 1'b1, 1'b0);

    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes instruction memory from a byte stream, the writer-side counterpart of the core's instruction fetch port. It holds the core in reset, takes a length-prefixed, checksummed byte stream over a valid/ready handshake, and packs bytes into 32-bit little-endian words. It writes each word to consecutive word addresses of instruction memory, then releases the core. It sits between an external byte source (UART receiver, test bench, debug port) and the instruction memory write port.

## Interface
- `ADDR_W`, default 8: instruction memory word-address width. Capacity is 2^ADDR_W words.
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst`, input, 1: reset, synchronous, active-low.
- `in_valid`, input, 1: source presents a byte.
- `in_data`, input, 8: byte value.
- `in_ready`, output, 1: loader accepts a byte. A byte transfers on a rising edge where `in_valid & in_ready`.
- `imem_we`, output, 1: one-cycle write strobe to instruction memory.
- `imem_addr`, output, ADDR_W: word address of the write.
- `imem_wdata`, output, 32: instruction word.
- `core_hold`, output, 1: holds the core in reset while 1. Drop to 0 only on successful load.
- `done`, output, 1: load succeeded. Sticky.
- `err`, output, 1: load failed. Sticky.

## Operation
- Stream format, in order:
  - LEN_LO, LEN_HI: 16-bit word count N, little-endian.
  - 4·N payload bytes: each word is sent LSB first.
  - CHK: XOR of all payload bytes. Length bytes are excluded. N=0 gives 0x00.
- States:
  - LEN0: accept byte → N[7:0] → LEN1.
  - LEN1: accept byte → N[15:8].
    - If N > 2^ADDR_W → ERR.
    - Else if N==0 → CHK.
    - Else → DATA.
  - DATA: accept bytes and shift into the word assembly register, byte_idx 0..3.
    - Each payload byte is XORed into the running checksum.
    - On acceptance of byte_idx 3, register `imem_wdata = {in_data, asm[23:0]}` and `imem_addr = word_idx`, and pulse `imem_we`.
    - word_idx increments after each write.
    - After word N-1 → CHK.
  - CHK: accept byte.
    - Byte equals the running XOR → DONE.
    - Otherwise → ERR.
  - DONE: `done=1`, `core_hold=0`, `in_ready=0`. Stays until reset.
  - ERR: `err=1`, `core_hold=1`, `in_ready=0`. Stays until reset.
- `in_ready`=1 in LEN0, LEN1, DATA and CHK. No backpressure inside a load: a byte is accepted every cycle `in_valid` is high, including the cycle `imem_we` is asserted.
- Bytes presented while in DONE or ERR are ignored.
- word_idx is ADDR_W+1 bits internally. N == 2^ADDR_W is legal: the last address is all-ones and `imem_addr` never wraps.
- No write occurs for a partial word; a load aborted by reset leaves partial memory contents as they are.
- `imem_addr` and `imem_wdata` hold their last written values between strobes.

## Timing
- While `rst`=0, at the clock edge: state=LEN0, checksum=0, word_idx=0, byte_idx=0.
  - Outputs: `in_ready=0`, `imem_we=0`, `imem_addr=0`, `imem_wdata=0`, `core_hold=1`, `done=0`, `err=0`.
- `in_ready` is registered. It rises on the first edge after `rst` returns to 1.
- `imem_we` is high for exactly the one cycle after the edge that accepted payload byte 3 of a word. `imem_addr` and `imem_wdata` are valid in that same cycle.
- `done`, `err` and `core_hold` change on the edge that accepts CHK. The length error sets `err` on the edge that accepts LEN_HI. In both cases `in_ready` goes to 0 on that same edge.
- Back-to-back bytes give one word per 4 cycles. Gaps in `in_valid` stall the state machine without side effects.
- Reset asserted in any state, including mid-word or mid-CHK, returns every output and internal register to its reset value on that edge.

## Test plan
- N=1 single load:
  - Stimulus: 01 00 13 00 50 00 43, back-to-back.
  - Response: one `imem_we` cycle with addr 0 and data 0x00500013; then `done=1`, `core_hold=0`, `err=0`, `in_ready=0`.
- N=0:
  - Stimulus: 00 00 00.
  - Response: no `imem_we`; `done=1` after the third byte.
- Bad checksum:
  - Stimulus: the N=1 stream with CHK=0x42.
  - Response: the write still occurs; then `err=1`, `core_hold=1`, `done=0`.
- Oversize length, ADDR_W=8:
  - Stimulus: 01 01.
  - Response: `err=1` on the LEN_HI edge; no writes; further bytes ignored.
- Full-capacity load, ADDR_W=8:
  - Stimulus: N=256 with random in_valid gaps; word k = 0xA5000000|k.
  - Response: 256 strobes at addr 0..255 in order with matching data; `done=1`.
- Mid-load reset:
  - Stimulus: `rst`=0 after payload byte 2 of word 1, then a fresh N=1 stream.
  - Response: all outputs at reset values; the new load writes addr 0; `done=1`.
